// File: rtl/squash_io_pkg.sv
//==============================================================================
// Module      : squash_io_pkg
// Description : Shared FSM state type and GPIO pin-map helpers for the
//               squash IO adapter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package squash_io_pkg;

   typedef enum logic [1:0] {
      WAIT_READY = 2'd0,
      HOLD       = 2'd1,
      DRIVE      = 2'd2
   } oeb_state_t;

   // Slice layout, LSB first: ext_reset_n, buttons, design outputs, debug pair.
   localparam int c_ext_reset_idx = 0;
   localparam int c_btn_lo        = 1;

   function automatic int out_lo(input int n_btn);
      return n_btn + 1;
   endfunction

   function automatic int dbg_reset_idx(input int n_btn, input int n_out);
      return n_btn + n_out + 1;
   endfunction

   function automatic int dbg_ready_idx(input int n_btn, input int n_out);
      return n_btn + n_out + 2;
   endfunction

   function automatic int io_width(input int n_btn, input int n_out);
      return n_btn + n_out + 3;
   endfunction

endpackage : squash_io_pkg

`default_nettype wire

// File: rtl/io_sync_debounce.sv
//==============================================================================
// Module      : io_sync_debounce
// Description : One input channel: SYNC_STAGES flop synchroniser followed by
//               an optional stable-count debouncer (DB_CYCLES = 0 bypasses it).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module io_sync_debounce #(
   parameter int   SYNC_STAGES = 2,
   parameter int   DB_CYCLES   = 4,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_din,
   output logic o_dout
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   w_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_din};
      end
   end

   assign w_sync = r_chain[SYNC_STAGES-1];

   generate
      if (DB_CYCLES == 0) begin : g_bypass
         assign o_dout = w_sync;
      end else begin : g_debounce
         localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
         localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

         logic               r_q;
         logic [c_cnt_w-1:0] r_cnt;

         // A change is accepted only after DB_CYCLES consecutive differing samples.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q   <= RESET_VAL;
               r_cnt <= '0;
            end else if (w_sync == r_q) begin
               r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
               r_q   <= w_sync;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + c_cnt_w'(1);
            end
         end

         assign o_dout = r_q;
      end
   endgenerate

endmodule : io_sync_debounce

`default_nettype wire

// File: rtl/squash_io_adapter.sv
//==============================================================================
// Module      : squash_io_adapter
// Description : Maps a game core's buttons and video/audio outputs onto a
//               contiguous GPIO slice with sync, debounce, reset stretch and
//               output-enable sequencing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module squash_io_adapter
   import squash_io_pkg::*;
#(
   parameter int N_BTN        = 4,
   parameter int N_OUT        = 6,
   parameter int SYNC_STAGES  = 2,
   parameter int DB_CYCLES    = 4,
   parameter int RST_STRETCH  = 4,
   parameter bit OEB_IN_RESET = 1'b1,
   parameter int IO_W         = io_width(N_BTN, N_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IO_W-1:0]  io_in,
   output logic [IO_W-1:0]  io_out,
   output logic [IO_W-1:0]  io_oeb,
   input  logic             gpio_ready,
   output logic [N_BTN-1:0] btn_n,
   input  logic [N_OUT-1:0] design_out,
   output logic             design_reset
);

   localparam int c_out_lo    = out_lo(N_BTN);
   localparam int c_dbg_reset = dbg_reset_idx(N_BTN, N_OUT);
   localparam int c_dbg_ready = dbg_ready_idx(N_BTN, N_OUT);
   localparam int c_str_w     = $clog2(RST_STRETCH + 1);
   localparam logic [c_str_w-1:0] c_str_max = c_str_w'(RST_STRETCH);

   logic               w_ext_sync;
   logic               w_ready_sync;
   logic               w_drive;
   logic               w_unused_io_in;
   logic [c_str_w-1:0] r_str_cnt;
   logic               r_design_reset;
   logic               r_ready_seen;
   oeb_state_t         r_state;
   oeb_state_t         w_state_next;

   // Pad bits at and above the design-output offset are outputs only.
   assign w_unused_io_in = ^io_in[IO_W-1:c_out_lo];

   io_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (0),
      .RESET_VAL   (1'b1)
   ) u_ext_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (io_in[c_ext_reset_idx]),
      .o_dout (w_ext_sync)
   );

   io_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (0),
      .RESET_VAL   (1'b0)
   ) u_ready_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (gpio_ready),
      .o_dout (w_ready_sync)
   );

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
         io_sync_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RESET_VAL   (1'b1)
         ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_din  (io_in[c_btn_lo + gi]),
            .o_dout (btn_n[gi])
         );
      end
   endgenerate

   // Stretch counter saturates at RST_STRETCH; any synced ext reset restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_str_cnt      <= '0;
         r_design_reset <= 1'b1;
      end else if (!w_ext_sync) begin
         r_str_cnt      <= '0;
         r_design_reset <= 1'b1;
      end else if (r_str_cnt != c_str_max) begin
         r_str_cnt <= r_str_cnt + c_str_w'(1);
         if (r_str_cnt == c_str_max - c_str_w'(1)) begin
            r_design_reset <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= WAIT_READY;
         r_ready_seen <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_ready_sync) begin
            r_ready_seen <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WAIT_READY: begin
            if (w_ready_sync || r_ready_seen) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (!r_design_reset) begin
               w_state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (r_design_reset && OEB_IN_RESET) begin
               w_state_next = HOLD;
            end
         end
         default: w_state_next = WAIT_READY;
      endcase
   end

   assign w_drive      = (r_state == DRIVE);
   assign design_reset = r_design_reset;

   always_comb begin
      io_out                       = '0;
      io_out[c_out_lo +: N_OUT]    = w_drive ? design_out : '0;
      io_out[c_dbg_reset]          = r_design_reset;
      io_out[c_dbg_ready]          = w_ready_sync;

      io_oeb                            = '0;
      io_oeb[c_ext_reset_idx +: N_BTN+1] = '1;
      io_oeb[c_out_lo +: N_OUT]         = {N_OUT{~w_drive}};
   end

endmodule : squash_io_adapter

`default_nettype wire

// File: tb/tb_squash_io_adapter.sv
//==============================================================================
// Module      : tb_squash_io_adapter
// Description : Self-checking bench for squash_io_adapter (both OEB_IN_RESET
//               builds side by side) against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_squash_io_adapter;

   localparam int RS = 4;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] io_in;
   logic        gpio_ready;
   logic [5:0]  design_out;
   logic [12:0] io_out_a, io_oeb_a, io_out_b, io_oeb_b;
   logic [3:0]  btn_n_a, btn_n_b;
   logic        dr_a, dr_b;

   int n_checks = 0;
   int n_errors = 0;

   squash_io_adapter #(.OEB_IN_RESET(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .io_in(io_in), .io_out(io_out_a), .io_oeb(io_oeb_a),
      .gpio_ready(gpio_ready), .btn_n(btn_n_a), .design_out(design_out), .design_reset(dr_a)
   );

   squash_io_adapter #(.OEB_IN_RESET(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .io_in(io_in), .io_out(io_out_b), .io_oeb(io_oeb_b),
      .gpio_ready(gpio_ready), .btn_n(btn_n_b), .design_out(design_out), .design_reset(dr_b)
   );

   always #5 clk = ~clk;

   // Reference model: delay lines for the synchronisers, "cycles differing"
   // per button, "cycles since ext reset was seen low", and the pin phase.
   logic [1:0] ext_pipe, rdy_pipe;
   logic [1:0] btn_pipe [4];
   logic [3:0] m_btn;
   int         m_diff [4];
   int         m_since;
   logic       m_dr;
   int         m_state_a, m_state_b;  // 0 waiting for ready, 1 holding, 2 driving
   logic       m_seen;
   logic       es, rs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_pipe = 2'b11;
         rdy_pipe = 2'b00;
         for (int b = 0; b < 4; b++) begin
            btn_pipe[b] = 2'b11;
            m_diff[b]   = 0;
         end
         m_btn = 4'hF; m_since = 0; m_dr = 1'b1;
         m_state_a = 0; m_state_b = 0; m_seen = 1'b0;
      end else begin
         es = ext_pipe[1];
         rs = rdy_pipe[1];
         for (int b = 0; b < 4; b++) begin
            if (btn_pipe[b][1] == m_btn[b]) m_diff[b] = 0;
            else begin
               m_diff[b] = m_diff[b] + 1;
               if (m_diff[b] >= DB) begin
                  m_btn[b]  = btn_pipe[b][1];
                  m_diff[b] = 0;
               end
            end
         end
         case (m_state_a)
            0: if (rs || m_seen) m_state_a = 1;
            1: if (!m_dr) m_state_a = 2;
            default: if (m_dr) m_state_a = 1;
         endcase
         case (m_state_b)
            0: if (rs || m_seen) m_state_b = 1;
            1: if (!m_dr) m_state_b = 2;
            default: ;
         endcase
         m_seen  = m_seen | rs;
         m_since = !es ? 0 : ((m_since < RS) ? m_since + 1 : m_since);
         m_dr    = (m_since < RS);
         ext_pipe = {ext_pipe[0], io_in[0]};
         rdy_pipe = {rdy_pipe[0], gpio_ready};
         for (int b = 0; b < 4; b++) btn_pipe[b] = {btn_pipe[b][0], io_in[1+b]};
      end
   end

   function automatic logic [30:0] exp_vec(input int st);
      logic        drive;
      logic [12:0] eo, eb;
      drive = (st == 2);
      eo = {rdy_pipe[1], m_dr, drive ? design_out : 6'h00, 5'h00};
      eb = {2'b00, {6{~drive}}, 5'h1F};
      return {eo, eb, m_btn, m_dr};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int fall;
      rst_n = 1'b0; io_in = 13'h1FFF; gpio_ready = 1'b0; design_out = 6'h2A;
      repeat (3) step();
      n_checks++;
      if (io_out_a !== 13'h0800) begin n_errors++; $display("FAIL reset_io_out got %h exp %h", io_out_a, 13'h0800); end
      n_checks++;
      if (io_oeb_a !== 13'h07FF) begin n_errors++; $display("FAIL reset_io_oeb_a got %h exp %h", io_oeb_a, 13'h07FF); end
      n_checks++;
      if (io_oeb_b !== 13'h07FF) begin n_errors++; $display("FAIL reset_io_oeb_b got %h exp %h", io_oeb_b, 13'h07FF); end
      n_checks++;
      if (btn_n_a !== 4'hF) begin n_errors++; $display("FAIL reset_btn_n got %h exp f", btn_n_a); end
      n_checks++;
      if (dr_a !== 1'b1) begin n_errors++; $display("FAIL reset_design_reset got %b exp 1", dr_a); end
      rst_n = 1'b1;
      fall  = -1;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (fall < 0 && dr_a === 1'b0) fall = n;
         n_checks++;
         if ({io_out_a, io_oeb_a, btn_n_a, dr_a} !== exp_vec(m_state_a)) begin
            n_errors++; $display("FAIL reset_model got %h exp %h", {io_out_a, io_oeb_a, btn_n_a, dr_a}, exp_vec(m_state_a));
         end
      end
      n_checks++;
      if (fall != 4) begin n_errors++; $display("FAIL reset_stretch_latency got %0d exp 4", fall); end
      for (int n = 0; n < 50; n++) begin
         step();
         n_checks++;
         if (io_oeb_a !== 13'h07FF) begin n_errors++; $display("FAIL reset_oeb_hold got %h exp %h", io_oeb_a, 13'h07FF); end
      end
   endtask

   task automatic test_ready_handshake();
      int open_at;
      gpio_ready = 1'b1;
      step();
      gpio_ready = 1'b0;
      open_at = -1;
      for (int n = 1; n <= 8; n++) begin
         step();
         if (open_at < 0 && io_oeb_a[10:5] === 6'h00) open_at = n;
         n_checks++;
         if ({io_out_a, io_oeb_a, btn_n_a, dr_a} !== exp_vec(m_state_a)) begin
            n_errors++; $display("FAIL ready_model got %h exp %h", {io_out_a, io_oeb_a, btn_n_a, dr_a}, exp_vec(m_state_a));
         end
      end
      n_checks++;
      if (open_at != 3) begin n_errors++; $display("FAIL ready_open_latency got %0d exp 3", open_at); end
      n_checks++;
      if (io_out_a[10:5] !== 6'h2A) begin n_errors++; $display("FAIL ready_passthru got %h exp 2a", io_out_a[10:5]); end
      for (int n = 0; n < 8; n++) begin
         design_out = 6'($urandom_range(0, 63));
         #1;
         n_checks++;
         if (io_out_a[10:5] !== design_out || io_out_b[10:5] !== design_out) begin
            n_errors++; $display("FAIL drive_passthru got %h/%h exp %h", io_out_a[10:5], io_out_b[10:5], design_out);
         end
         step();
      end
   endtask

   task automatic test_debounce();
      int fall, rise;
      io_in[2] = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         step();
         if (n == 3) io_in[2] = 1'b1;
         n_checks++;
         if (btn_n_a[1] !== 1'b1) begin n_errors++; $display("FAIL debounce_glitch got %b exp 1", btn_n_a[1]); end
      end
      io_in[2] = 1'b0;
      fall = -1; rise = -1;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 6) io_in[2] = 1'b1;
         if (fall < 0 && btn_n_a[1] === 1'b0) fall = n;
         if (n > 6 && rise < 0 && btn_n_a[1] === 1'b1) rise = n - 6;
         n_checks++;
         if ({io_out_a, io_oeb_a, btn_n_a, dr_a} !== exp_vec(m_state_a)) begin
            n_errors++; $display("FAIL debounce_model got %h exp %h", {io_out_a, io_oeb_a, btn_n_a, dr_a}, exp_vec(m_state_a));
         end
      end
      n_checks++;
      if (fall != 6) begin n_errors++; $display("FAIL debounce_fall_latency got %0d exp 6", fall); end
      n_checks++;
      if (rise != 6) begin n_errors++; $display("FAIL debounce_rise_latency got %0d exp 6", rise); end
   endtask

   task automatic test_ext_reset();
      int rise, fall, closed, reopen;
      io_in[0] = 1'b0;
      rise = -1; fall = -1; closed = -1; reopen = -1;
      for (int n = 1; n <= 16; n++) begin
         step();
         if (n == 1) io_in[0] = 1'b1;
         if (rise < 0 && dr_a === 1'b1) rise = n;
         if (rise > 0 && fall < 0 && dr_a === 1'b0) fall = n;
         if (closed < 0 && io_oeb_a[10:5] === 6'h3F) closed = n;
         if (closed > 0 && reopen < 0 && io_oeb_a[10:5] === 6'h00) reopen = n;
         n_checks++;
         if ({io_out_a, io_oeb_a, btn_n_a, dr_a} !== exp_vec(m_state_a) ||
             {io_out_b, io_oeb_b, btn_n_b, dr_b} !== exp_vec(m_state_b)) begin
            n_errors++; $display("FAIL extrst_model got %h/%h exp %h/%h", {io_out_a, io_oeb_a, btn_n_a, dr_a},
                                 {io_out_b, io_oeb_b, btn_n_b, dr_b}, exp_vec(m_state_a), exp_vec(m_state_b));
         end
         n_checks++;
         if (io_oeb_b[10:5] !== 6'h00) begin n_errors++; $display("FAIL extrst_oeb_b_open got %h exp 00", io_oeb_b[10:5]); end
      end
      n_checks++;
      if (rise != 3 || fall != 7) begin n_errors++; $display("FAIL extrst_timing got rise %0d fall %0d exp 3 7", rise, fall); end
      n_checks++;
      if (closed != 4 || reopen != 8) begin n_errors++; $display("FAIL extrst_oeb_timing got %0d %0d exp 4 8", closed, reopen); end

      io_in[0] = 1'b0;
      rise = -1; fall = -1;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 1 || n == 4) io_in[0] = 1'b1;
         if (n == 3) io_in[0] = 1'b0;
         if (rise < 0 && dr_a === 1'b1) rise = n;
         if (rise > 0 && fall < 0 && dr_a === 1'b0) fall = n;
         n_checks++;
         if ({io_out_b, io_oeb_b, btn_n_b, dr_b} !== exp_vec(m_state_b)) begin
            n_errors++; $display("FAIL restart_model_b got %h exp %h", {io_out_b, io_oeb_b, btn_n_b, dr_b}, exp_vec(m_state_b));
         end
      end
      n_checks++;
      if (rise != 3 || fall != 10) begin n_errors++; $display("FAIL restart_timing got rise %0d fall %0d exp 3 10", rise, fall); end
   endtask

   task automatic test_simultaneous();
      int open_at;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (io_oeb_a[10:5] !== 6'h3F || io_oeb_b[10:5] !== 6'h3F) begin
         n_errors++; $display("FAIL async_rst_oeb got %h/%h exp 3f", io_oeb_a[10:5], io_oeb_b[10:5]);
      end
      n_checks++;
      if (dr_a !== 1'b1 || dr_b !== 1'b1) begin n_errors++; $display("FAIL async_rst_dr got %b%b exp 11", dr_a, dr_b); end
      step();
      rst_n = 1'b1;
      repeat (6) step();
      n_checks++;
      if (io_oeb_a[10:5] !== 6'h3F || dr_a !== 1'b0) begin
         n_errors++; $display("FAIL simul_pre got oeb %h dr %b exp 3f 0", io_oeb_a[10:5], dr_a);
      end
      io_in[0] = 1'b0; gpio_ready = 1'b1;
      open_at = -1;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (n == 1) io_in[0] = 1'b1;
         if (open_at < 0 && io_oeb_a[10:5] === 6'h00) open_at = n;
         n_checks++;
         if ({io_out_a, io_oeb_a, btn_n_a, dr_a} !== exp_vec(m_state_a) ||
             {io_out_b, io_oeb_b, btn_n_b, dr_b} !== exp_vec(m_state_b)) begin
            n_errors++; $display("FAIL simul_model got %h/%h exp %h/%h", {io_out_a, io_oeb_a, btn_n_a, dr_a},
                                 {io_out_b, io_oeb_b, btn_n_b, dr_b}, exp_vec(m_state_a), exp_vec(m_state_b));
         end
      end
      n_checks++;
      if (open_at != 8) begin n_errors++; $display("FAIL simul_open_latency got %0d exp 8", open_at); end
      gpio_ready = 1'b0;
   endtask

   task automatic test_random();
      int len;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int seg = 0; seg < 60; seg++) begin
         len             = $urandom_range(1, 8);
         io_in[12:5]     = 8'($urandom);
         io_in[4:1]      = 4'($urandom_range(0, 15));
         io_in[0]        = ($urandom_range(0, 9) != 0);
         gpio_ready      = ($urandom_range(0, 3) == 0);
         design_out      = 6'($urandom_range(0, 63));
         for (int n = 0; n < len; n++) begin
            step();
            n_checks++;
            if ({io_out_a, io_oeb_a, btn_n_a, dr_a} !== exp_vec(m_state_a)) begin
               n_errors++; $display("FAIL random_model_a got %h exp %h", {io_out_a, io_oeb_a, btn_n_a, dr_a}, exp_vec(m_state_a));
            end
            n_checks++;
            if ({io_out_b, io_oeb_b, btn_n_b, dr_b} !== exp_vec(m_state_b)) begin
               n_errors++; $display("FAIL random_model_b got %h exp %h", {io_out_b, io_oeb_b, btn_n_b, dr_b}, exp_vec(m_state_b));
            end
         end
      end
      io_in[0] = 1'b1;
   endtask

   initial begin
      test_reset();
      test_ready_handshake();
      test_debounce();
      test_ext_reset();
      test_simultaneous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog run did not complete");
      $fatal(1, "watchdog");
   end

endmodule : tb_squash_io_adapter

`default_nettype wire
